systolic_out_collector: RTL and testbench
=========================================

# systolic_out_collector

Receiving end of the systolic accumulator output interface. Captures the 16-lane `en_out` strobes and the two 22-bit result planes (batch 0 and batch 1, PE rows 0–3 × columns 0–3), then requantizes each result to 8 bits. Assembles complete 4×4×2 tiles in a double-buffered store and streams them to the write-back path as 32-bit valid/ready beats.

## Interface
- `DATA_WIDTH_I`, 22, width of each accumulator result (signed two's complement)
- `DATA_WIDTH_Q`, 8, requantized output width (signed); beats are 4×`DATA_WIDTH_Q`
- `clk`  in  1  clock
- `rst`  in  1  reset; **asynchronous, active-high**; one clock domain only
- `start`  in  1  frame boundary: clears fill-bank lane flags and `overflow`
- `shift`  in  5  right-shift amount for requantization; sampled per capture
- `en_out`  in  16  lane strobes; lane i = row*4+col
- `din0`  in  16×`DATA_WIDTH_I`  batch-0 results; lane i at bits [i*W +: W]
- `din1`  in  16×`DATA_WIDTH_I`  batch-1 results, same packing
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  4×`DATA_WIDTH_Q`  four PEs of one row, col 0 at LSB
- `m_last`  out  1  final beat (8th) of a tile
- `busy`  out  1  any lane flag set or drain bank occupied
- `overflow`  out  1  sticky capture-loss flag

## Operation
- Two banks, each 32 × `DATA_WIDTH_Q` plus a 16-bit lane-flag vector. One bank fills while the other drains.
- Capture: on a cycle with `en_out[i]`=1, lane i of the fill bank stores `q(din0[i])` and `q(din1[i])`, and flag i is set. Lanes may arrive skewed across any number of cycles.
- Requantize `q(x)`:
  - If `shift`>0, add rounding term 1<<(`shift`−1).
  - Arithmetic right shift by `shift`.
  - Saturate to the `DATA_WIDTH_Q` range; see Configuration.
  - All intermediates are `DATA_WIDTH_I`+1 bits signed.
- Tile complete: all 16 flags set. If the drain bank is empty, the banks swap the same cycle and the new fill bank's flags clear. Otherwise the completed fill bank holds until the drain bank empties.
- Drain order: 8 beats. Beats 0–3 are batch 0, rows 0–3; beats 4–7 are batch 1, rows 0–3. `m_last` is set on beat 7.
- Beat handshake: a beat transfers when `m_valid`&&`m_ready`. `m_data` and `m_last` hold stable while `m_valid`&&!`m_ready`.
- Overflow (sets `overflow`; captured data is handled as follows):
  - Strobe arriving while the fill bank is complete and waiting: data dropped.
  - Strobe to a lane whose flag is already set in an incomplete fill bank: data overwrites.
- `start` clears fill-bank flags and `overflow`. It does not disturb the drain bank or an in-progress drain. If `start` and `en_out` occur in the same cycle, flags clear first, then that cycle's strobes are captured.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `overflow`=0. Both banks are empty and the beat counter is 0.
- Latency: `m_valid` rises 2 cycles after the cycle carrying the last missing lane strobe, when the drain bank was empty.
- Throughput: one beat per cycle with `m_ready` held high. Back-to-back tiles have no bubble when the next tile completed during the drain: beat 0 of the next tile follows beat 7 of the current one.
- Reset asserted mid-capture or mid-drain aborts immediately. All state returns to reset values and partial tiles are discarded.
- `overflow` rises the cycle after the offending strobe.

## Configuration
- `COLLECT_RELU_EN` defined: negative results clamp to 0, so the saturation range is [0, 2^(`DATA_WIDTH_Q`−1)−1], i.e. [0,127].
- Not defined: signed saturation to [−2^(`DATA_WIDTH_Q`−1), 2^(`DATA_WIDTH_Q`−1)−1], i.e. [−128,127].

## Test plan
- Single tile, simultaneous strobes:
  - Stimulus: `en_out`=16'hFFFF for 1 cycle, `shift`=4, `din0` lane i = 16*i, `din1` lane i = −16*i, `m_ready`=1.
  - Required: 8 beats starting 2 cycles later. Beat 0 = {8'd3,8'd2,8'd1,8'd0}; beats 4–7 carry −i (0 under `COLLECT_RELU_EN`). `m_last` only on beat 7.
- Skewed arrival: strobe lane i at cycle i (16 cycles).
  - Required: `m_valid` first at cycle 17. Data matches the simultaneous case.
- Rounding and saturation with `shift`=1:
  - din 3 → 2.
  - din −3 → −1.
  - din 1000 → 127.
  - din −1000 → −128 without the macro, 0 with it.
- Backpressure:
  - Stimulus: `m_ready` low for 5 cycles on beat 2; a second tile completes meanwhile.
  - Required: beat 2 held stable, no beat lost. Second tile drains immediately after the first `m_last`; `overflow`=0.
- Overflow:
  - Stimulus: 3 complete tiles while `m_ready`=0, then one more strobe.
  - Required: `overflow`=1 the next cycle; first two tiles later drain intact. A subsequent `start` clears `overflow`.
- Reset mid-drain: assert `rst` on beat 3.
  - Required: all outputs 0 the same cycle. After release, a fresh tile drains from beat 0.

Source files
------------

// File: rtl/systolic_out_collector_if.sv
// systolic_out_collector_if
// Bundles the capture-side and stream-side signals of the output collector.
//   start, shift, en_out, din0, din1 : accumulator side, driven towards the collector
//   m_valid, m_data, m_last, m_ready : 32-bit write-back beat stream
//   busy, overflow                   : status
// Modport 'slave' is the collector's view; modport 'master' is the view of
// whatever drives the accumulator outputs and consumes the beats.
interface systolic_out_collector_if #(
  parameter int DATA_WIDTH_I = 22,
  parameter int DATA_WIDTH_Q = 8
);
  logic                          start;
  logic [4:0]                    shift;
  logic [15:0]                   en_out;
  logic [16*DATA_WIDTH_I-1:0]    din0;
  logic [16*DATA_WIDTH_I-1:0]    din1;
  logic                          m_valid;
  logic                          m_ready;
  logic [4*DATA_WIDTH_Q-1:0]     m_data;
  logic                          m_last;
  logic                          busy;
  logic                          overflow;

  modport master (
    output start, shift, en_out, din0, din1, m_ready,
    input  m_valid, m_data, m_last, busy, overflow
  );

  modport slave (
    input  start, shift, en_out, din0, din1, m_ready,
    output m_valid, m_data, m_last, busy, overflow
  );
endinterface

// File: rtl/systolic_out_collector.sv
// systolic_out_collector
// Captures 16 lanes x 2 batches of accumulator results, requantizes each to
// DATA_WIDTH_Q bits (round, arithmetic shift, saturate), assembles 4x4x2 tiles
// in a double-buffered store and streams each tile as 8 valid/ready beats.
// Ports: clk, rst (async, active-high), bus (systolic_out_collector_if.slave).
// Optional feature: define COLLECT_RELU_EN to clamp negative results to 0.
module systolic_out_collector #(
  parameter int DATA_WIDTH_I = 22,
  parameter int DATA_WIDTH_Q = 8
) (
  input logic                     clk,
  input logic                     rst,
  systolic_out_collector_if.slave bus
);
  localparam int WI1     = DATA_WIDTH_I + 1;
  localparam int LANES   = 16;
  localparam int ENTRIES = 32;
  localparam int WORD_W  = 4 * DATA_WIDTH_Q;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  // Round-half-up, arithmetic shift, saturate; all intermediates WI1 bits signed.
  function automatic logic [DATA_WIDTH_Q-1:0] requant(input logic [DATA_WIDTH_I-1:0] x,
                                                      input logic [4:0] sh);
    logic signed [WI1-1:0] v, rnd, r, qmax, qmin;
    v = $signed({x[DATA_WIDTH_I-1], x});
    if (sh != 5'd0) rnd = $signed({{(WI1-1){1'b0}}, 1'b1} << (sh - 5'd1));
    else            rnd = $signed({WI1{1'b0}});
    r = (v + rnd) >>> sh;
    qmax = $signed({{(WI1-DATA_WIDTH_Q+1){1'b0}}, {(DATA_WIDTH_Q-1){1'b1}}});
`ifdef COLLECT_RELU_EN
    qmin = $signed({WI1{1'b0}});
`else
    qmin = $signed({{(WI1-DATA_WIDTH_Q+1){1'b1}}, {(DATA_WIDTH_Q-1){1'b0}}});
`endif
    if (r > qmax)      r = qmax;
    else if (r < qmin) r = qmin;
    else               r = r;
    return r[DATA_WIDTH_Q-1:0];
  endfunction

  // Bank storage: entry = batch*16 + row*4 + col
  logic [DATA_WIDTH_Q-1:0] mem_r [2][ENTRIES];
  logic [LANES-1:0]        flags_r;
  logic                    fill_sel_r;      // drain bank is always ~fill_sel_r
  state_t                  state_r, state_next_s;
  logic [2:0]              beat_r, beat_next_s, beat_inc_s;
  logic                    m_valid_r, m_last_r, busy_r, overflow_r;
  logic [WORD_W-1:0]       m_data_r;

  logic                    tile_complete_s, beat_done_s, last_done_s, drain_free_s, swap_s;
  logic                    drop_s, ovf_event_s, wr_sel_s;
  logic [LANES-1:0]        base_flags_s, wr_en_s, flags_next_s;
  logic [WORD_W-1:0]       fill_word_s, next_word_s, m_data_next_s;
  logic                    m_valid_next_s, m_last_next_s, busy_next_s, overflow_next_s;

  // Capture control: swap decision, which lanes get written, overflow events.
  always_comb begin : capture_ctrl
    tile_complete_s = &flags_r;
    beat_done_s     = (state_r == S_DRAIN) && m_valid_r && bus.m_ready;
    last_done_s     = beat_done_s && (beat_r == 3'd7);
    // A drain bank finishing its last beat this cycle counts as empty, which
    // lets the next tile follow without a bubble.
    drain_free_s    = (state_r == S_IDLE) || last_done_s;
    swap_s          = tile_complete_s && drain_free_s && !bus.start;
    if (swap_s || bus.start) base_flags_s = {LANES{1'b0}};
    else                     base_flags_s = flags_r;
    // A completed bank that cannot swap rejects all strobes.
    if (tile_complete_s && !swap_s && !bus.start) begin
      drop_s  = |bus.en_out;
      wr_en_s = {LANES{1'b0}};
    end else begin
      drop_s  = 1'b0;
      wr_en_s = bus.en_out;
    end
    // On a swap, this cycle's strobes land in the freshly emptied bank.
    wr_sel_s     = swap_s ? ~fill_sel_r : fill_sel_r;
    flags_next_s = base_flags_s | wr_en_s;
    ovf_event_s  = drop_s || (|(bus.en_out & base_flags_s));
  end

  // Candidate beat words: beat 0 of the fill bank, and the next beat of the drain bank.
  always_comb begin : word_select
    fill_word_s = {WORD_W{1'b0}};
    next_word_s = {WORD_W{1'b0}};
    beat_inc_s  = beat_r + 3'd1;
    for (int c = 0; c < 4; c++) begin
      fill_word_s[c*DATA_WIDTH_Q +: DATA_WIDTH_Q] = mem_r[fill_sel_r][{3'd0, 2'(c)}];
      next_word_s[c*DATA_WIDTH_Q +: DATA_WIDTH_Q] = mem_r[~fill_sel_r][{beat_inc_s, 2'(c)}];
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_next_s;
  end

  // Drain FSM next-state logic.
  always_comb begin : fsm_next
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (swap_s) state_next_s = S_DRAIN;
        else        state_next_s = S_IDLE;
      end
      S_DRAIN: begin
        if (last_done_s && !swap_s) state_next_s = S_IDLE;
        else                        state_next_s = S_DRAIN;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Drain FSM output logic: next values of the registered stream and status outputs.
  always_comb begin : fsm_out
    beat_next_s    = beat_r;
    m_valid_next_s = m_valid_r;
    m_data_next_s  = m_data_r;
    m_last_next_s  = m_last_r;
    if (swap_s) begin
      beat_next_s    = 3'd0;
      m_valid_next_s = 1'b1;
      m_data_next_s  = fill_word_s;
      m_last_next_s  = 1'b0;
    end else if (last_done_s) begin
      beat_next_s    = 3'd0;
      m_valid_next_s = 1'b0;
      m_data_next_s  = {WORD_W{1'b0}};
      m_last_next_s  = 1'b0;
    end else if (beat_done_s) begin
      beat_next_s    = beat_inc_s;
      m_valid_next_s = 1'b1;
      m_data_next_s  = next_word_s;
      m_last_next_s  = (beat_r == 3'd6);
    end else begin
      beat_next_s    = beat_r;
    end
    busy_next_s     = (|flags_next_s) || (state_next_s == S_DRAIN);
    overflow_next_s = bus.start ? 1'b0 : (overflow_r | ovf_event_s);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r    <= {LANES{1'b0}};
      fill_sel_r <= 1'b0;
      beat_r     <= 3'd0;
      m_valid_r  <= 1'b0;
      m_data_r   <= {WORD_W{1'b0}};
      m_last_r   <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      flags_r    <= flags_next_s;
      fill_sel_r <= swap_s ? ~fill_sel_r : fill_sel_r;
      beat_r     <= beat_next_s;
      m_valid_r  <= m_valid_next_s;
      m_data_r   <= m_data_next_s;
      m_last_r   <= m_last_next_s;
      busy_r     <= busy_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  // Bank storage: requantize and store strobed lanes of both batches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int e = 0; e < ENTRIES; e++)
          mem_r[b][e] <= {DATA_WIDTH_Q{1'b0}};
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_en_s[i]) begin
          mem_r[wr_sel_s][i]         <= requant(bus.din0[i*DATA_WIDTH_I +: DATA_WIDTH_I], bus.shift);
          mem_r[wr_sel_s][i + LANES] <= requant(bus.din1[i*DATA_WIDTH_I +: DATA_WIDTH_I], bus.shift);
        end
      end
    end
  end

  assign bus.m_valid  = m_valid_r;
  assign bus.m_data   = m_data_r;
  assign bus.m_last   = m_last_r;
  assign bus.busy     = busy_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_systolic_out_collector.sv
// tb_systolic_out_collector
// Directed bench for systolic_out_collector: reset state, simultaneous and
// skewed tile capture, a table of requantization vectors (one lane each),
// backpressure with a back-to-back tile, overflow and reset mid-drain.
module tb_systolic_out_collector;
`ifdef COLLECT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk;
  logic rst;
  systolic_out_collector_if bus ();

  systolic_out_collector dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int shift; int d0; int d1; int e0; int e1; } vec_t;
  vec_t tbl [16];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] qexp(input int v);
    if (RELU && v < 0) return 8'd0;
    return 8'(v);
  endfunction

  // Drive a full tile (din0 lane = 16*(a+i), din1 lane = 16*(b-i), shift 4)
  // and optionally queue its 8 expected beats.
  task automatic load_tile(input int a, input int b, input bit push);
    for (int i = 0; i < 16; i++) begin
      bus.din0[i*22 +: 22] = 22'(16 * (a + i));
      bus.din1[i*22 +: 22] = 22'(16 * (b - i));
    end
    bus.shift  = 5'd4;
    bus.en_out = 16'hFFFF;
    if (push) begin
      for (int bt = 0; bt < 8; bt++) begin
        logic [31:0] w;
        int ln;
        w = 32'h0;
        for (int c = 0; c < 4; c++) begin
          ln = (bt % 4) * 4 + c;
          w[c*8 +: 8] = (bt < 4) ? qexp(a + ln) : qexp(b - ln);
        end
        expq.push_back(w);
      end
    end
  endtask

  // Accept n beats with m_ready high, comparing against the expected queue.
  task automatic drain(input int n, input int budget);
    int got;
    int cyc;
    logic [31:0] e;
    got = 0;
    cyc = 0;
    bus.m_ready = 1'b1;
    while (got < n && cyc < budget) begin
      if (bus.m_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 32'h0;
        chk($sformatf("beat%0d_data", got), bus.m_data, e);
        chk($sformatf("beat%0d_last", got), 32'(bus.m_last), 32'((got % 8) == 7));
        got++;
      end
      tick();
      cyc++;
    end
    if (got < n) chk("drain_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    int beats, stall, c7;
    tbl[0]  = '{1, 3, -3, 2, -1};
    tbl[1]  = '{1, 1000, -1000, 127, -128};
    tbl[2]  = '{0, 5, -7, 5, -7};
    tbl[3]  = '{0, 127, 128, 127, 127};
    tbl[4]  = '{0, -128, -129, -128, -128};
    tbl[5]  = '{4, 80, -80, 5, -5};
    tbl[6]  = '{2, 6, -6, 2, -1};
    tbl[7]  = '{2, 5, -5, 1, -1};
    tbl[8]  = '{3, 12, -12, 2, -1};
    tbl[9]  = '{8, 32767, -32768, 127, -128};
    tbl[10] = '{10, 2097151, -2097152, 127, -128};
    tbl[11] = '{1, 0, -1, 0, 0};
    tbl[12] = '{1, 1, -2, 1, -1};
    tbl[13] = '{5, 100, -100, 3, -3};
    tbl[14] = '{0, 0, -1, 0, -1};
    tbl[15] = '{6, 8160, 8127, 127, 127};

    rst = 1'b1;
    bus.start = 1'b0; bus.shift = 5'd0; bus.en_out = 16'h0;
    bus.din0 = '0; bus.din1 = '0; bus.m_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", bus.m_data, 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);

    // Simultaneous strobes: valid exactly 2 cycles later
    bus.m_ready = 1'b1;
    load_tile(0, 0, 1'b1);
    tick();
    bus.en_out = 16'h0;
    chk("sim_valid_c1", 32'(bus.m_valid), 32'd0);
    chk("sim_busy_c1", 32'(bus.busy), 32'd1);
    tick();
    chk("sim_valid_c2", 32'(bus.m_valid), 32'd1);
    drain(8, 20);
    chk("sim_idle_after", 32'(bus.m_valid), 32'd0);

    // Skewed arrival, one table vector per lane with its own shift
    for (int bt = 0; bt < 8; bt++) begin
      logic [31:0] w;
      int ln;
      w = 32'h0;
      for (int c = 0; c < 4; c++) begin
        ln = (bt % 4) * 4 + c;
        w[c*8 +: 8] = (bt < 4) ? qexp(tbl[ln].e0) : qexp(tbl[ln].e1);
      end
      expq.push_back(w);
    end
    for (int i = 0; i < 16; i++) begin
      bus.shift = 5'(tbl[i].shift);
      bus.din0[i*22 +: 22] = 22'(tbl[i].d0);
      bus.din1[i*22 +: 22] = 22'(tbl[i].d1);
      bus.en_out = 16'h0001 << i;
      tick();
    end
    bus.en_out = 16'h0;
    chk("skew_valid_c16", 32'(bus.m_valid), 32'd0);
    tick();
    chk("skew_valid_c17", 32'(bus.m_valid), 32'd1);
    drain(8, 20);

    // Backpressure on beat 2 while a second tile completes
    load_tile(1, 0, 1'b1);
    tick();
    bus.en_out = 16'h0;
    beats = 0; stall = 0; c7 = -100;
    for (int cyc = 0; cyc < 100 && beats < 16; cyc++) begin
      bus.en_out = 16'h0;
      if (bus.m_valid && beats == 2 && stall < 5) begin
        bus.m_ready = 1'b0;
        if (stall == 0) load_tile(40, 90, 1'b1);
        chk("bp_hold_data", bus.m_data, expq[0]);
        chk("bp_hold_valid", 32'(bus.m_valid), 32'd1);
        stall++;
      end else begin
        bus.m_ready = 1'b1;
        if (bus.m_valid) begin
          chk($sformatf("bp_beat%0d_data", beats), bus.m_data, expq.pop_front());
          chk($sformatf("bp_beat%0d_last", beats), 32'(bus.m_last), 32'((beats % 8) == 7));
          if (beats == 7) c7 = cyc;
          if (beats == 8) chk("bp_no_bubble", 32'(cyc), 32'(c7 + 1));
          beats++;
        end
      end
      tick();
    end
    bus.en_out = 16'h0;
    chk("bp_beat_count", 32'(beats), 32'd16);
    chk("bp_overflow", 32'(bus.overflow), 32'd0);

    // Overflow: three tiles with m_ready low, then one more strobe
    bus.m_ready = 1'b0;
    load_tile(2, 1, 1'b1);
    tick(); bus.en_out = 16'h0; tick(); tick(); tick();
    load_tile(20, 10, 1'b1);
    tick(); bus.en_out = 16'h0; tick(); tick(); tick();
    chk("ovf_before", 32'(bus.overflow), 32'd0);
    chk("ovf_busy", 32'(bus.busy), 32'd1);
    load_tile(60, 5, 1'b0);
    tick();
    bus.en_out = 16'h0;
    chk("ovf_third_tile", 32'(bus.overflow), 32'd1);
    bus.en_out = 16'h0001;
    tick();
    bus.en_out = 16'h0;
    chk("ovf_extra_strobe", 32'(bus.overflow), 32'd1);
    drain(16, 60);
    chk("ovf_valid_after", 32'(bus.m_valid), 32'd0);
    chk("ovf_busy_after", 32'(bus.busy), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Reset mid-drain on beat 3
    expq.delete();
    bus.m_ready = 1'b1;
    load_tile(5, 3, 1'b1);
    tick(); bus.en_out = 16'h0; tick();
    tick(); tick(); tick();
    chk("rmd_beat3", bus.m_data, expq[3]);
    #2 rst = 1'b1;
    #1;
    chk("rmd_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rmd_m_data", bus.m_data, 32'd0);
    chk("rmd_m_last", 32'(bus.m_last), 32'd0);
    chk("rmd_busy", 32'(bus.busy), 32'd0);
    chk("rmd_overflow", 32'(bus.overflow), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    expq.delete();
    load_tile(10, 2, 1'b1);
    tick(); bus.en_out = 16'h0;
    chk("rmd_valid_c1", 32'(bus.m_valid), 32'd0);
    tick();
    chk("rmd_valid_c2", 32'(bus.m_valid), 32'd1);
    drain(8, 20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
